// File: rtl/reg_write_queue_pkg.sv
// Shared types and helpers for the register-write queue feeding the GPU register bank.
// Field widths are upper bounds; instances use the low ADDR_W / WIDTH bits.
package reg_write_queue_pkg;

   localparam int MAX_ADDR_W = 8;
   localparam int MAX_REGS   = 256;
   localparam int MAX_DATA_W = 64;

   typedef struct packed {
      logic [MAX_ADDR_W-1:0] addr;
      logic [MAX_DATA_W-1:0] data;
   } wr_cmd_t;

   localparam logic [MAX_REGS-1:0] REG_LOAD_IDLE = '1;

   function automatic logic [MAX_REGS-1:0] load_n_onehot(input logic [MAX_ADDR_W-1:0] addr);
      logic [MAX_REGS-1:0] v;
      v       = REG_LOAD_IDLE;
      v[addr] = 1'b0;
      return v;
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Generic single-clock FIFO with wrap-bit pointers; pushes when full and pops when empty are ignored.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       push,
   input  logic                       pop,
   input  logic [WIDTH-1:0]           din,
   output logic [WIDTH-1:0]           dout,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     count
);
   localparam int PTR_W = $clog2(DEPTH);

   logic [PTR_W:0]   wr_ptr_q, wr_ptr_d;
   logic [PTR_W:0]   rd_ptr_q, rd_ptr_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic             do_push, do_pop;

   assign empty   = (wr_ptr_q == rd_ptr_q);
   assign full    = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                    (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
   assign count   = wr_ptr_q - rd_ptr_q;
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign dout    = mem_q[rd_ptr_q[PTR_W-1:0]];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (do_push) wr_ptr_d = wr_ptr_q + (PTR_W+1)'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + (PTR_W+1)'(1);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Storage carries no reset: an empty FIFO never exposes its contents.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q[PTR_W-1:0]] <= din;
   end

endmodule

// File: rtl/reg_write_queue.sv
// Queues host register writes and issues one per cycle onto the shared D bus with an
// active-low per-register load strobe; writes to missing registers raise a sticky error.
module reg_write_queue
   import reg_write_queue_pkg::*;
#(
   parameter int WIDTH  = 32,
   parameter int NREGS  = 8,
   parameter int ADDR_W = 3,
   parameter int DEPTH  = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              wr_valid,
   output logic              wr_ready,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [WIDTH-1:0]  wr_data,
   output logic [WIDTH-1:0]  reg_d,
   output logic [NREGS-1:0]  reg_load_n,
   output logic              busy,
   output logic              err,
   input  logic              err_clr
);
   localparam int                 CNT_W     = $clog2(DEPTH) + 1;
   localparam int                 ENT_W     = ADDR_W + WIDTH;
   localparam logic [NREGS-1:0]   LOAD_IDLE = REG_LOAD_IDLE[NREGS-1:0];
   localparam logic [MAX_ADDR_W:0] NREGS_LIM = (MAX_ADDR_W+1)'(NREGS);

   logic                fifo_push, fifo_pop, fifo_full, fifo_empty;
   logic [CNT_W-1:0]    fifo_count;
   logic [ENT_W-1:0]    head_ent;
   wr_cmd_t             head_cmd;
   logic [MAX_REGS-1:0] head_sel_n;
   logic                head_addr_ok;
   logic [WIDTH-1:0]    reg_d_q, reg_d_d;
   logic [NREGS-1:0]    reg_load_n_q, reg_load_n_d;
   logic                err_q, err_d;
   logic                unused_ok;

   assign wr_ready  = (fifo_count != CNT_W'(DEPTH));
   assign fifo_push = wr_valid && !fifo_full;
   assign fifo_pop  = !fifo_empty;

   sync_fifo #(
      .WIDTH (ENT_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (fifo_push),
      .pop   (fifo_pop),
      .din   ({wr_addr, wr_data}),
      .dout  (head_ent),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   always_comb begin
      head_cmd      = '0;
      head_cmd.addr = MAX_ADDR_W'(head_ent[ENT_W-1:WIDTH]);
      head_cmd.data = MAX_DATA_W'(head_ent[WIDTH-1:0]);
   end

   assign head_addr_ok = ({1'b0, head_cmd.addr} < NREGS_LIM);
   assign head_sel_n   = load_n_onehot(head_cmd.addr);
   // Upper struct / strobe bits beyond this instance's geometry are intentionally dropped.
   assign unused_ok    = &{1'b0, head_cmd.data, head_sel_n};

   // Issue stage: FIFO head -> registered D bus, strobe and error flag
   always_comb begin
      reg_d_d      = reg_d_q;
      reg_load_n_d = LOAD_IDLE;
      err_d        = err_q && !err_clr;
      if (fifo_pop) begin
         if (head_addr_ok) begin
            reg_d_d      = head_cmd.data[WIDTH-1:0];
            reg_load_n_d = head_sel_n[NREGS-1:0];
         end else begin
            err_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         reg_d_q      <= '0;
         reg_load_n_q <= LOAD_IDLE;
         err_q        <= 1'b0;
      end else begin
         reg_d_q      <= reg_d_d;
         reg_load_n_q <= reg_load_n_d;
         err_q        <= err_d;
      end
   end

   assign reg_d      = reg_d_q;
   assign reg_load_n = reg_load_n_q;
   assign err        = err_q;
   assign busy       = !fifo_empty || (reg_load_n_q != LOAD_IDLE);

endmodule

// File: tb/tb_reg_write_queue.sv
// Scoreboard bench for reg_write_queue: a queue-based reference model predicts strobes,
// D bus, error and handshake; a negedge monitor pops and compares.
module tb_reg_write_queue;
   localparam int WIDTH  = 32;
   localparam int NREGS  = 6;
   localparam int ADDR_W = 3;
   localparam int DEPTH  = 4;

   logic              clk      = 1'b0;
   logic              reset    = 1'b1;
   logic              wr_valid = 1'b0;
   logic              wr_ready;
   logic [ADDR_W-1:0] wr_addr  = '0;
   logic [WIDTH-1:0]  wr_data  = '0;
   logic [WIDTH-1:0]  reg_d;
   logic [NREGS-1:0]  reg_load_n;
   logic              busy;
   logic              err;
   logic              err_clr  = 1'b0;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   reg_write_queue #(
      .WIDTH  (WIDTH),
      .NREGS  (NREGS),
      .ADDR_W (ADDR_W),
      .DEPTH  (DEPTH)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .wr_valid   (wr_valid),
      .wr_ready   (wr_ready),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .reg_d      (reg_d),
      .reg_load_n (reg_load_n),
      .busy       (busy),
      .err        (err),
      .err_clr    (err_clr)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   typedef struct {
      int unsigned      addr;
      logic [WIDTH-1:0] data;
   } cmd_t;

   // Reference model: accepted commands wait in mq; one leaves per edge.
   cmd_t             mq[$];
   cmd_t             exp_q[$];
   logic [WIDTH-1:0] m_regd   = '0;
   bit               m_err    = 1'b0;
   bit               m_strobe = 1'b0;
   cmd_t             mc;
   bit               m_acc, m_inv;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         mq.delete();
         exp_q.delete();
         m_regd   = '0;
         m_err    = 1'b0;
         m_strobe = 1'b0;
      end else begin
         m_acc    = wr_valid && (mq.size() < DEPTH);
         m_inv    = 1'b0;
         m_strobe = 1'b0;
         if (mq.size() > 0) begin
            mc = mq.pop_front();
            if (mc.addr < NREGS) begin
               exp_q.push_back(mc);
               m_regd   = mc.data;
               m_strobe = 1'b1;
            end else begin
               m_inv = 1'b1;
            end
         end
         m_err = m_inv || (m_err && !err_clr);
         if (m_acc) begin
            mc.addr = 32'(wr_addr);
            mc.data = wr_data;
            mq.push_back(mc);
         end
      end
   end

   // Monitor
   int   lows, idx;
   cmd_t e;

   always @(negedge clk) begin
      check("wr_ready", 64'(wr_ready), 64'(mq.size() < DEPTH));
      check("busy", 64'(busy), 64'((mq.size() > 0) || m_strobe));
      check("err", 64'(err), 64'(m_err));
      check("reg_d", 64'(reg_d), 64'(m_regd));
      lows = 0;
      idx  = 0;
      for (int i = 0; i < NREGS; i++) begin
         if (!reg_load_n[i]) begin
            lows++;
            idx = i;
         end
      end
      check("one_strobe_max", 64'(lows <= 1), 64'(1));
      if (lows > 0) begin
         if (exp_q.size() == 0) begin
            check("unexpected_strobe", 64'(lows), 64'(0));
         end else begin
            e = exp_q.pop_front();
            check("strobe_addr", 64'(idx), 64'(e.addr));
            check("strobe_data", 64'(reg_d), 64'(e.data));
         end
      end else if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check("strobe_present", 64'(lows), 64'(1));
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic put(input logic [ADDR_W-1:0] a, input logic [WIDTH-1:0] d);
      wr_valid = 1'b1;
      wr_addr  = a;
      wr_data  = d;
   endtask

   logic [WIDTH-1:0] last_d;

   initial begin
      repeat (2) step();
      #2 reset = 1'b0;
      step();
      check("rst_ready", 64'(wr_ready), 64'(1));
      check("rst_load_n", 64'(reg_load_n), 64'(6'h3f));
      check("rst_reg_d", 64'(reg_d), 64'(0));
      check("rst_err", 64'(err), 64'(0));
      check("rst_busy", 64'(busy), 64'(0));

      // single write
      put(3'd3, 32'hDEADBEEF);
      step();
      wr_valid = 1'b0;
      step();
      check("single_strobe", 64'(reg_load_n), 64'(6'b110111));
      check("single_d", 64'(reg_d), 64'(32'hDEADBEEF));
      check("single_busy_hi", 64'(busy), 64'(1));
      step();
      check("single_idle", 64'(reg_load_n), 64'(6'h3f));
      check("single_busy_lo", 64'(busy), 64'(0));

      // burst to addrs 0..3
      for (int i = 0; i < 4; i++) begin
         put(3'(i), 32'h100 + 32'(i));
         step();
         check("burst_ready", 64'(wr_ready), 64'(1));
      end
      wr_valid = 1'b0;
      repeat (3) step();

      // continuous stream wrapping the pointers
      last_d = '0;
      for (int i = 0; i < 12; i++) begin
         last_d = $urandom;
         put(3'(i % NREGS), last_d);
         step();
      end
      wr_valid = 1'b0;
      repeat (3) step();

      // invalid address, set-wins, then clear
      put(3'd7, 32'hBAD00007);
      step();
      wr_valid = 1'b0;
      step();
      check("err_set", 64'(err), 64'(1));
      check("err_no_strobe", 64'(reg_load_n), 64'(6'h3f));
      check("err_d_hold", 64'(reg_d), 64'(last_d));
      put(3'd7, 32'hBAD00017);
      step();
      wr_valid = 1'b0;
      err_clr  = 1'b1;
      step();
      err_clr = 1'b0;
      check("err_set_wins", 64'(err), 64'(1));
      step();
      err_clr = 1'b1;
      step();
      err_clr = 1'b0;
      check("err_cleared", 64'(err), 64'(0));

      // same address back-to-back
      put(3'd2, 32'h1);
      step();
      put(3'd2, 32'h2);
      step();
      wr_valid = 1'b0;
      step();
      check("same_addr_d", 64'(reg_d), 64'(2));
      check("same_addr_strobe", 64'(reg_load_n), 64'(6'b111011));
      repeat (2) step();

      // asynchronous reset in the middle of a burst
      put(3'd0, 32'hAAAA0000);
      step();
      put(3'd1, 32'hBBBB1111);
      step();
      put(3'd4, 32'hCCCC4444);
      step();
      wr_valid = 1'b0;
      #3 reset = 1'b1;
      #1;
      check("async_rst_load_n", 64'(reg_load_n), 64'(6'h3f));
      check("async_rst_busy", 64'(busy), 64'(0));
      check("async_rst_ready", 64'(wr_ready), 64'(1));
      #2 reset = 1'b0;
      for (int k = 0; k < 4; k++) begin
         step();
         check("post_rst_idle", 64'(reg_load_n), 64'(6'h3f));
      end

      // random traffic
      for (int n = 0; n < 400; n++) begin
         wr_valid = ($urandom_range(0, 9) < 7);
         wr_addr  = 3'($urandom_range(0, 7));
         wr_data  = $urandom;
         err_clr  = ($urandom_range(0, 7) == 0);
         step();
      end
      wr_valid = 1'b0;
      err_clr  = 1'b0;
      repeat (4) step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "time limit reached");
   end

endmodule

// File: doc/reg_write_queue.md
# reg_write_queue

Buffers register-write commands from the host bus and applies them, one per cycle, to the GPU's bank of `register` instances. Sits directly upstream of the register bank: drives the shared D bus and one active-low load strobe per register. Absorbs back-to-back host writes in a small FIFO. Flags writes to non-existent registers with a sticky error.

## Interface
- `WIDTH`, default 32: data width; matches the register bank width.
- `NREGS`, default 8: number of registers driven; valid range 2..256.
- `ADDR_W`, default 3: address width; must satisfy 2^ADDR_W >= NREGS.
- `DEPTH`, default 4: FIFO entries; power of two, at least 2.
- `clk`, input, 1: single clock; all state changes on its rising edge.
- `reset`, input, 1: asynchronous, active-high; clears all state immediately.
- `wr_valid`, input, 1: host presents a write command.
- `wr_ready`, output, 1: queue can accept; a command transfers when `wr_valid` and `wr_ready` are both high at a clock edge.
- `wr_addr`, input, ADDR_W: target register index.
- `wr_data`, input, WIDTH: value to write.
- `reg_d`, output, WIDTH: data to the register bank D inputs; registered.
- `reg_load_n`, output, NREGS: per-register load strobe, active-low; at most one bit low in any cycle; registered.
- `busy`, output, 1: high while the FIFO is non-empty or a strobe is asserted.
- `err`, output, 1: sticky flag for writes to an address >= NREGS.
- `err_clr`, input, 1: clears `err` on the next edge.

## Operation
- Reset values: `reg_d` = 0, `reg_load_n` = all ones, `err` = 0, FIFO empty, `wr_ready` = 1, `busy` = 0.
- Push: a command is written at the FIFO tail on a transfer edge.
- `wr_ready` = !full. It is combinational from the FIFO count only, with no dependence on `wr_valid`.
- Issue stage: on every edge where the FIFO is non-empty, the head is popped.
  - Valid address (< NREGS): `reg_d` is set to its data, and `reg_load_n` goes all ones except bit [addr] = 0.
  - Invalid address: `reg_load_n` goes all ones, `reg_d` holds its previous value, and `err` is set.
- Edges with the FIFO empty: `reg_load_n` returns to all ones and `reg_d` holds.
- Push and pop on the same edge: both happen and the count is unchanged.
  - When full, no push can occur.
  - When empty, the pushed entry is not popped that edge; there is no bypass.
- Pointers are ADDR-free binary counters of log2(DEPTH)+1 bits. Wrap-around is natural modulo 2·DEPTH. Full is when the MSBs differ and the rest are equal.
- `err`: a set event and `err_clr` on the same edge leave `err` = 1, because set wins.
- Writes to the same address complete in acceptance order, so the last write wins.
- `reset` asserted mid-operation: queued commands are discarded, and any asserted strobe deasserts asynchronously.

## Timing
- Transfer at edge N: the entry is in the FIFO after N. At edge N+1 it is popped, and `reg_load_n[addr]` is low during cycle N+1..N+2. The target register captures at edge N+2.
- Latency from accept to register Q update is 2 edges when the queue is empty. Each older queued entry adds one edge.
- Sustained throughput is one write per cycle. With continuous `wr_valid`, `wr_ready` never drops.
- `busy` falls in the cycle after the last strobe deasserts.

## Structure
- Shared package holds:
  - a write-command struct {addr, data};
  - constant `REG_LOAD_IDLE` for the all-ones strobe vector;
  - a function returning the active-low one-hot vector for an address.
- Sub-module `sync_fifo` is parameterised (WIDTH, DEPTH) and provides push/pop/full/empty/count. It is reused elsewhere in the GPU. The issue stage and error logic stay in `reg_write_queue`.

## Test plan
- Single write after reset: addr 3, data 0xDEADBEEF accepted at edge N. Expect `reg_load_n` = 8'b1111_0111 for exactly cycle N+1, `reg_d` = 0xDEADBEEF, and `busy` low after N+2.
- Burst of 4 writes to addrs 0..3 on consecutive cycles. Expect `wr_ready` to stay high, strobes 0,1,2,3 on consecutive cycles, and only one bit low at a time.
- Fill: hold strobes by pushing 5 writes with DEPTH=4 while each pop is matched by a push. Check `wr_ready` = 0 only when count = 4. Check that pointer wrap through 8+ entries preserves order and data.
- Invalid address with NREGS=6 and ADDR_W=3: write addr 7. Expect no strobe, `reg_d` unchanged, and `err` = 1. Pulse `err_clr` with a simultaneous second addr-7 pop: expect `err` to stay 1. Then clear alone: expect `err` = 0.
- Reset mid-burst: queue 3 writes, then assert `reset` asynchronously between edges. Expect `reg_load_n` = all ones immediately, and no strobes after release.
- Same-address ordering: write addr 2 with 0x1 then 0x2 back-to-back. Expect two strobes on bit 2, the last with `reg_d` = 0x2.
